// File: rtl/dt_pkg.sv
// Shared geometry, address widths, FSM encoding and bit-order helper for the distance-map binary packer.
// Latency/backpressure: not applicable (declarations only).
package dt_pkg;

  localparam int IMG_W   = 128;
  localparam int IMG_H   = 128;
  localparam int WORD_W  = 16;

  localparam int PIX_AW  = $clog2(IMG_W * IMG_H);
  localparam int WORD_AW = $clog2(IMG_W * IMG_H / WORD_W);
  localparam int FILL_W  = $clog2(WORD_W);
  localparam int CNT_W   = PIX_AW + 1;

  localparam logic [PIX_AW-1:0] PIX_LAST = PIX_AW'(IMG_W * IMG_H - 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_DRAIN,
    ST_FIN
  } st_t;

  // Bit position of a column inside its packed word: lowest column lands in the MSB.
  function automatic int bit_index(input int col);
    return WORD_W - 1 - (col % WORD_W);
  endfunction

endpackage

// File: rtl/dt_bin_pack_if.sv
// Control, result-RAM read and binary-RAM write signals of the packer.
// No handshake: reads are issued every cycle in RUN and both RAMs are assumed always ready.
interface dt_bin_pack_if;
  import dt_pkg::*;

  logic                 start;
  logic [7:0]           thr;
  logic                 busy;
  logic                 done;
  logic                 res_rd;
  logic [PIX_AW-1:0]    res_addr;
  logic [7:0]           res_di;
  logic                 bin_wr;
  logic [WORD_AW-1:0]   bin_addr;
  logic [WORD_W-1:0]    bin_do;
  logic [CNT_W-1:0]     ones_cnt;

  modport master (
    output start, thr, res_di,
    input  busy, done, res_rd, res_addr, bin_wr, bin_addr, bin_do, ones_cnt
  );

  modport slave (
    input  start, thr, res_di,
    output busy, done, res_rd, res_addr, bin_wr, bin_addr, bin_do, ones_cnt
  );

endinterface

// File: rtl/dt_bit_packer.sv
// Shifts thresholded pixels MSB-first into words, emits one write per full word and counts ones.
// Latency: word presented the cycle after its last pixel; no backpressure, accepts one pixel per cycle.
module dt_bit_packer
  import dt_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  input  logic               clr,
  input  logic               pix_vld,
  input  logic               pix_bit,
  output logic               word_vld,
  output logic [WORD_AW-1:0] word_addr,
  output logic [WORD_W-1:0]  word_dat,
  output logic [CNT_W-1:0]   ones_cnt
);

  logic [WORD_W-1:0]  sr_q, sr_d;
  logic [FILL_W-1:0]  fill_q, fill_d;
  logic [WORD_AW-1:0] wcnt_q, wcnt_d;
  logic               wr_q, wr_d;
  logic [WORD_AW-1:0] waddr_q, waddr_d;
  logic [WORD_W-1:0]  wdat_q, wdat_d;
  logic [CNT_W-1:0]   ones_q, ones_d;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sr_q    <= '0;
      fill_q  <= '0;
      wcnt_q  <= '0;
      wr_q    <= 1'b0;
      waddr_q <= '0;
      wdat_q  <= '0;
      ones_q  <= '0;
    end else begin
      sr_q    <= sr_d;
      fill_q  <= fill_d;
      wcnt_q  <= wcnt_d;
      wr_q    <= wr_d;
      waddr_q <= waddr_d;
      wdat_q  <= wdat_d;
      ones_q  <= ones_d;
    end
  end

  always_comb begin
    sr_d    = sr_q;
    fill_d  = fill_q;
    wcnt_d  = wcnt_q;
    wr_d    = 1'b0;
    waddr_d = waddr_q;
    wdat_d  = wdat_q;
    ones_d  = ones_q;
    if (clr) begin
      sr_d    = '0;
      fill_d  = '0;
      wcnt_d  = '0;
      waddr_d = '0;
      wdat_d  = '0;
      ones_d  = '0;
    end else if (pix_vld) begin
      sr_d   = {sr_q[WORD_W-2:0], pix_bit};
      fill_d = fill_q + FILL_W'(1);
      ones_d = ones_q + CNT_W'(pix_bit);
      // The fill counter wraps on its own after the last pixel of a word.
      if (fill_q == FILL_W'(WORD_W - 1)) begin
        wr_d    = 1'b1;
        wdat_d  = sr_d;
        waddr_d = wcnt_q;
        wcnt_d  = wcnt_q + WORD_AW'(1);
      end
    end
  end

  assign word_vld  = wr_q;
  assign word_addr = waddr_q;
  assign word_dat  = wdat_q;
  assign ones_cnt  = ones_q;

endmodule

// File: rtl/dt_bin_pack.sv
// Thresholds the distance map to 1 bit/pixel and packs 16 pixels MSB-first per binary-RAM word (option DT_BIN_PACK_BORDER_CLR_EN).
// Latency: start -> done in IMG_W*IMG_H+3 cycles; no backpressure, one read per cycle, RAMs always accept.
module dt_bin_pack
  import dt_pkg::*;
(
  input  logic         clk,
  input  logic         reset,
  dt_bin_pack_if.slave bus
);

  st_t               state_q, state_d;
  logic [PIX_AW-1:0] addr_q, addr_d;
  logic [7:0]        thr_q, thr_d;
  logic              done_q, done_d;
  logic              rd_vld_q;
  logic              clr;
  logic              pix_hit;
  logic              pix_bit;
  logic              word_vld;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= ST_IDLE;
      addr_q   <= '0;
      thr_q    <= '0;
      done_q   <= 1'b0;
      rd_vld_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      thr_q    <= thr_d;
      done_q   <= done_d;
      rd_vld_q <= (state_q == ST_RUN);
    end
  end

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    thr_d   = thr_q;
    done_d  = done_q;
    clr     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          thr_d   = bus.thr;
          addr_d  = '0;
          done_d  = 1'b0;
          clr     = 1'b1;
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        if (addr_q == PIX_LAST) begin
          state_d = ST_DRAIN;
        end else begin
          addr_d = addr_q + PIX_AW'(1);
        end
      end
      ST_DRAIN: begin
        // The final write can only come once the last read data has been consumed.
        if (!rd_vld_q && word_vld) begin
          done_d  = 1'b1;
          state_d = ST_FIN;
        end
      end
      ST_FIN:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  assign pix_hit = (bus.res_di >= thr_q);

`ifdef DT_BIN_PACK_BORDER_CLR_EN
  localparam int COL_W = $clog2(IMG_W);
  localparam int ROW_W = PIX_AW - COL_W;

  logic [PIX_AW-1:0] pix_q;
  logic [ROW_W-1:0]  pix_row;
  logic [COL_W-1:0]  pix_col;
  logic              border;

  // Index of the pixel whose data is on res_di this cycle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pix_q <= '0;
    end else begin
      pix_q <= addr_q;
    end
  end

  assign pix_row = pix_q[PIX_AW-1:COL_W];
  assign pix_col = pix_q[COL_W-1:0];
  assign border  = (pix_row == '0) || (pix_row == ROW_W'(IMG_H - 1)) ||
                   (pix_col == '0) || (pix_col == COL_W'(IMG_W - 1));
  assign pix_bit = pix_hit & ~border;
`else
  assign pix_bit = pix_hit;
`endif

  dt_bit_packer u_packer (
    .clk       (clk),
    .reset     (reset),
    .clr       (clr),
    .pix_vld   (rd_vld_q),
    .pix_bit   (pix_bit),
    .word_vld  (word_vld),
    .word_addr (bus.bin_addr),
    .word_dat  (bus.bin_do),
    .ones_cnt  (bus.ones_cnt)
  );

  assign bus.bin_wr   = word_vld;
  assign bus.res_rd   = (state_q == ST_RUN);
  assign bus.res_addr = addr_q;
  assign bus.busy     = (state_q == ST_RUN) || (state_q == ST_DRAIN);
  assign bus.done     = done_q;

endmodule

// File: tb/tb_dt_bin_pack.sv
// Scoreboard bench for dt_bin_pack: reference words are pushed per run, a negedge monitor pops and compares each write.
`timescale 1ns/1ps
module tb_dt_bin_pack;

  localparam int W          = 128;
  localparam int H          = 128;
  localparam int WW         = 16;
  localparam int NPIX       = W * H;
  localparam int NWORD      = NPIX / WW;
  localparam int RUN_CYCLES = NPIX + 3;
  localparam int BOUND      = 20000;

  typedef struct packed {
    logic [15:0] addr;
    logic [15:0] dat;
  } wexp_t;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  dt_bin_pack_if bus();

  dt_bin_pack dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  logic [7:0] mem [NPIX];
  wexp_t      exp_q [$];
  int         wcyc_q [$];
  int         n_chk  = 0;
  int         n_fail = 0;
  int         cyc    = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Synchronous result RAM: data appears the cycle after the read is issued.
  always @(posedge clk) begin
    if (bus.res_rd) bus.res_di <= mem[bus.res_addr];
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic bit model_bit(input int idx, input logic [7:0] t);
    bit b;
    b = (mem[idx] >= t);
`ifdef DT_BIN_PACK_BORDER_CLR_EN
    begin
      int row, col;
      row = idx / W;
      col = idx % W;
      if (row == 0 || row == H - 1 || col == 0 || col == W - 1) b = 1'b0;
    end
`endif
    return b;
  endfunction

  task automatic push_expect(input logic [7:0] t, output int ones);
    logic [15:0] w;
    ones = 0;
    for (int k = 0; k < NWORD; k++) begin
      w = '0;
      for (int j = 0; j < WW; j++) begin
        if (model_bit(k * WW + j, t)) begin
          w[WW - 1 - j] = 1'b1;
          ones++;
        end
      end
      exp_q.push_back('{addr: 16'(k), dat: w});
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_busy"},     bus.busy,     0);
    chk({tag, "_done"},     bus.done,     0);
    chk({tag, "_res_rd"},   bus.res_rd,   0);
    chk({tag, "_res_addr"}, bus.res_addr, 0);
    chk({tag, "_bin_wr"},   bus.bin_wr,   0);
    chk({tag, "_bin_addr"}, bus.bin_addr, 0);
    chk({tag, "_bin_do"},   bus.bin_do,   0);
    chk({tag, "_ones_cnt"}, bus.ones_cnt, 0);
  endtask

  // Monitor: read address sequence, write ordering/timing and scoreboard pops.
  bit prev_rd = 1'b0;
  bit prev_wr = 1'b0;
  int rd_exp  = 0;
  always @(negedge clk) begin
    if (!reset) begin
      prev_rd = 1'b0;
      prev_wr = 1'b0;
    end else begin
      if (!bus.busy) begin
        chk("rd_when_idle", bus.res_rd, 0);
        chk("wr_when_idle", bus.bin_wr, 0);
      end
      if (bus.res_rd) begin
        if (!prev_rd) rd_exp = 0;
        chk("res_addr", bus.res_addr, rd_exp);
        if (rd_exp % WW == WW - 1) wcyc_q.push_back(cyc + 2);
        rd_exp++;
      end else if (prev_rd) begin
        chk("read_count", rd_exp, NPIX);
      end
      if (bus.bin_wr) begin
        wexp_t e;
        chk("wr_back_to_back", prev_wr, 0);
        chk("wr_expected_pending", exp_q.size() > 0, 1);
        chk("wr_cycle_pending", wcyc_q.size() > 0, 1);
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          chk("bin_addr", bus.bin_addr, e.addr);
          chk("bin_do", bus.bin_do, e.dat);
        end
        if (wcyc_q.size() > 0) chk("wr_latency", cyc, wcyc_q.pop_front());
      end
      prev_rd = bus.res_rd;
      prev_wr = bus.bin_wr;
    end
  end

  task automatic run_image(input logic [7:0] t, input bit disturb, input bit abort);
    int ones;
    int sc;
    int waited;
    push_expect(t, ones);
    @(negedge clk);
    bus.thr   = t;
    bus.start = 1'b1;
    sc        = cyc;
    @(negedge clk);
    bus.start = 1'b0;
    bus.thr   = ~t;
    chk("done_cleared", bus.done, 0);
    chk("busy_set", bus.busy, 1);
    if (disturb) begin
      repeat (3000) @(negedge clk);
      bus.start = 1'b1;
      bus.thr   = 8'h00;
      @(negedge clk);
      bus.start = 1'b0;
    end
    if (abort) begin
      waited = 0;
      while (!(bus.res_rd && bus.res_addr == 5000) && waited < BOUND) begin
        @(negedge clk);
        waited++;
      end
      chk("abort_reached", waited < BOUND, 1);
      reset = 1'b0;
      #1;
      chk_zero("abort");
      repeat (2) @(negedge clk);
      exp_q.delete();
      wcyc_q.delete();
      reset = 1'b1;
      @(negedge clk);
      chk_zero("abort_release");
      return;
    end
    waited = 0;
    while (!bus.done && waited < BOUND) begin
      @(negedge clk);
      waited++;
    end
    chk("done_seen", bus.done, 1);
    chk("done_cycle", cyc - sc, RUN_CYCLES);
    chk("busy_at_done", bus.busy, 0);
    chk("ones_cnt", bus.ones_cnt, ones);
    chk("words_missing", exp_q.size(), 0);
    chk("latency_missing", wcyc_q.size(), 0);
    exp_q.delete();
    wcyc_q.delete();
    @(negedge clk);
    chk("done_held", bus.done, 1);
  endtask

  initial begin
    bus.start = 1'b0;
    bus.thr   = 8'h00;
    reset     = 1'b1;
    #2 reset  = 1'b0;
    repeat (3) @(negedge clk);
    chk_zero("reset");
    reset = 1'b1;
    @(negedge clk);

    foreach (mem[i]) mem[i] = 8'h00;
    run_image(8'd1, 1'b0, 1'b0);

    foreach (mem[i]) mem[i] = 8'h03;
    run_image(8'd3, 1'b0, 1'b0);

    // Single set pixel; a mid-run start with thr=0 must not disturb the run.
    foreach (mem[i]) mem[i] = 8'h00;
    mem[2 * W + 17] = 8'h05;
    run_image(8'd1, 1'b1, 1'b0);

    foreach (mem[i]) mem[i] = 8'($urandom);
    run_image(8'($urandom), 1'b0, 1'b1);

    foreach (mem[i]) mem[i] = ($urandom_range(0, 3) == 0) ? 8'hFF : 8'($urandom_range(0, 255));
    run_image(8'd255, 1'b0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
